// File: rtl/mainmem_backdoor_arb.sv
// mainmem_backdoor_arb: round-robin multi-channel burst arbiter onto a single main-memory port.
// Optional BACKDOOR_BYTE_MASK_EN passes the winner's byte mask through on write beats.
module mainmem_backdoor_arb #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH-1:0]          ch_we,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
   input  logic [NUM_CH*LEN_W-1:0]    ch_len,
   input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
   input  logic [NUM_CH*DATA_W/8-1:0] ch_mask,
   output logic [NUM_CH-1:0]          ch_gnt,
   output logic [NUM_CH-1:0]          ch_wready,
   output logic [NUM_CH-1:0]          ch_rvalid,
   output logic [NUM_CH-1:0]          ch_done,
   output logic [DATA_W-1:0]          ch_rdata,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic [DATA_W/8-1:0]        mem_mask,
   input  logic [DATA_W-1:0]          mem_rdata
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;
   state_t            state, state_nx;
   logic [CW-1:0]     last_q, win_q, pick;
   logic              found;
   logic [ADDR_W-1:0] base_q, addr_sum;
   logic              we_q, rv_q;
   logic [LEN_W-1:0]  len_q, beat_q;
   logic [DATA_W-1:0] rdata_q;
   logic [BYTES-1:0]  wmask;
`ifdef BACKDOOR_BYTE_MASK_EN
   assign wmask = ch_mask[int'(win_q)*BYTES +: BYTES];
`else
   logic unused_mask;
   assign unused_mask = ^ch_mask;
   assign wmask = '1;
`endif
   assign ch_rdata = rdata_q;
   assign addr_sum = base_q + (ADDR_W'(beat_q) << OFF);
   // descending scan so the channel closest after last_q is the one that sticks
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_req[(int'(last_q) + 1 + i) % NUM_CH]) begin
            pick  = CW'((int'(last_q) + 1 + i) % NUM_CH);
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_nx  = state;
      ch_gnt    = '0;
      ch_wready = '0;
      ch_done   = '0;
      ch_rvalid = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mask  = '0;
      ch_rvalid[win_q] = rv_q;
      case (state)
         IDLE: if (found && !rst) begin
            ch_gnt[pick] = 1'b1;
            state_nx     = BURST;
         end
         BURST: begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = addr_sum & ~ADDR_W'(BYTES - 1);
            if (we_q) begin
               ch_wready[win_q] = 1'b1;
               mem_wdata        = ch_wdata[int'(win_q)*DATA_W +: DATA_W];
               mem_mask         = wmask;
            end
            if (beat_q == len_q) state_nx = we_q ? DONE : DRAIN;
         end
         DRAIN: state_nx = DONE;
         default: begin
            ch_done[win_q] = 1'b1;
            state_nx       = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         last_q  <= CW'(NUM_CH - 1);
         win_q   <= '0;
         base_q  <= '0;
         we_q    <= 1'b0;
         len_q   <= '0;
         beat_q  <= '0;
         rv_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state <= state_nx;
         rv_q  <= state == BURST && !we_q;
         if (state == BURST && !we_q) rdata_q <= mem_rdata;
         if (state == BURST) beat_q <= beat_q + 1'b1;
         if (state == IDLE && found) begin
            win_q  <= pick;
            last_q <= pick;
            base_q <= ch_addr[int'(pick)*ADDR_W +: ADDR_W];
            we_q   <= ch_we[pick];
            len_q  <= ch_len[int'(pick)*LEN_W +: LEN_W];
            beat_q <= '0;
         end
      end
   end
endmodule

// File: doc/mainmem_backdoor_arb.md
MAINMEM_BACKDOOR_ARB -- requirements
Module: mainmem_backdoor_arb

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of requesting channels (1..8).
REQ-002 SHALL provide parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL provide parameter DATA_W, default 64, memory beat width (64 or 128).
REQ-004 SHALL provide parameter LEN_W, default 4, burst-length field width; a burst is ch_len+1 beats.
REQ-005 SHALL provide port clk  input  1  sole clock; one clock domain, all logic on its rising edge.
REQ-006 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide ports ch_req, ch_we  input  NUM_CH each  per-channel request and write-not-read.
REQ-008 SHALL provide ports ch_addr  input  NUM_CH*ADDR_W, and ch_len  input  NUM_CH*LEN_W  per-channel start address and beats-1.
REQ-009 SHALL provide ports ch_wdata  input  NUM_CH*DATA_W, and ch_mask  input  NUM_CH*DATA_W/8  per-channel write data and byte mask.
REQ-010 SHALL provide ports ch_gnt, ch_wready, ch_rvalid, ch_done  output  NUM_CH each, plus ch_rdata  output  DATA_W (shared).
REQ-011 SHALL provide ports mem_req, mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_mask  output  DATA_W/8; mem_rdata  input  DATA_W.

Function
REQ-012 SHALL implement states IDLE, BURST, DRAIN, DONE.
REQ-013 IDLE: when any ch_req is high, SHALL pick a winner round-robin starting at last_winner+1 (mod NUM_CH), latch its addr/we/len, pulse ch_gnt[winner] one cycle, go BURST next cycle.
REQ-014 BURST: SHALL issue exactly one beat per cycle, mem_req=1, mem_we=latched we, mem_addr=base+beat*(DATA_W/8) with low log2(DATA_W/8) bits forced 0.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_W (base 0xFFFF_FFF8, 2 beats, DATA_W=64 -> 0xFFFF_FFF8, 0x0000_0000).
REQ-016 Write beats: ch_wready[winner]=1 in the issue cycle; mem_wdata/mem_mask driven combinationally from the winner's ch_wdata/ch_mask.
REQ-017 Read beats: mem_rdata is registered; ch_rdata/ch_rvalid[winner] SHALL appear exactly one cycle after the beat's mem_req.
REQ-018 After the last beat, writes SHALL go to DONE; reads SHALL go to DRAIN for one cycle (final rvalid), then DONE.
REQ-019 DONE: ch_done[winner] SHALL pulse one cycle; SHALL return to IDLE; earliest next grant is the cycle after.
REQ-020 ch_req deassertion during BURST/DRAIN SHALL be ignored; burst completes with latched parameters.
REQ-021 A channel holding ch_req through DONE SHALL be re-arbitrated normally; it cannot win twice in a row while another channel requests.
REQ-022 mem_req, ch_wready, ch_rvalid SHALL be 0 in IDLE and DONE; all unused outputs 0.

Reset
REQ-023 rst SHALL force IDLE, all outputs 0, ch_rdata 0, last_winner=NUM_CH-1 (channel 0 wins first).
REQ-024 rst during BURST/DRAIN SHALL abort the burst in the next cycle with no ch_done pulse and no further mem_req.

Configuration
REQ-025 Macro BACKDOOR_BYTE_MASK_EN: when defined, mem_mask SHALL follow the winner's ch_mask on write beats.
REQ-026 Without BACKDOOR_BYTE_MASK_EN, ch_mask SHALL be ignored and mem_mask SHALL be all ones on write beats (full-width access only); mem_mask is 0 on reads in both builds.

Verification
REQ-027 Ch1 write, addr 0x8000_0000, len 3, wdata 0x1111..0x4444 -> 4 consecutive mem_req, addrs 0x8000_0000/08/10/18, ch_done[1] one cycle after last beat.
REQ-028 Ch2 read, addr 0x8000_0010, len 1, mem_rdata 0xAAAA then 0xBBBB -> ch_rvalid[2] two cycles, ch_rdata in order, one DRAIN cycle, ch_done[2].
REQ-029 Ch0..3 all request at once, len 0 each -> grants in order 0,1,2,3; repeat with all held -> order continues 0,1,2,3.
REQ-030 Ch0 write len 2, rst asserted on second beat -> no third mem_req, no ch_done, next request from ch3 then ch0 -> ch0 granted first.
REQ-031 Write with ch_mask 0x0F -> mem_mask 0x0F with BACKDOOR_BYTE_MASK_EN, 0xFF without.
REQ-032 Base 0xFFFF_FFF8, len 1 write -> mem_addr 0xFFFF_FFF8 then 0x0000_0000.
